// File: rtl/tiny_dnn_pkg.sv
// Shared definitions for the tiny_dnn datapath: array geometry, address field
// widths and the sequencer state encoding.
package tiny_dnn_pkg;

  localparam int F_NUM  = 16;
  localparam int F_SIZE = 512;
  localparam int LANE_W = 4;
  localparam int ADDR_W = 9;
  localparam int A_W    = LANE_W + ADDR_W;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WLOAD = 3'd1,
    INIT  = 3'd2,
    EXEC  = 3'd3,
    DRAIN = 3'd4,
    OUT   = 3'd5
  } seq_state_t;

endpackage

// File: rtl/tiny_dnn_seq.sv
// Layer sequencer for the 16-lane bf16 dot-product array: one command runs
// weight load, accumulator clear, activation stream and result drain.
module tiny_dnn_seq #(
  parameter int F_NUM     = tiny_dnn_pkg::F_NUM,
  parameter int F_SIZE    = tiny_dnn_pkg::F_SIZE,
  parameter int DRAIN_CYC = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [9:0]  in_num,
  input  logic        skip_wload,
  output logic        busy,
  output logic        done,
  output logic        err,
  input  logic        w_valid,
  output logic        w_ready,
  input  logic [31:0] w_data,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [31:0] s_data,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [31:0] m_data,
  output logic        m_last,
  output logic        dnn_write,
  output logic        dnn_init,
  output logic        dnn_exec,
  output logic [12:0] dnn_a,
  output logic [31:0] dnn_d,
  input  logic [31:0] dnn_x
);
  import tiny_dnn_pkg::*;

  seq_state_t        state_r, next_state_s;
  logic [LANE_W-1:0] lane_r;
  logic [9:0]        k_r, n_r;
  logic [1:0]        dcnt_r;
  logic              settle_r;
  logic              busy_r, done_r, err_r, w_ready_r, s_ready_r, m_valid_r, m_last_r;
  logic              dnn_write_r, dnn_init_r, dnn_exec_r;
  logic [A_W-1:0]    dnn_a_r;
  logic [31:0]       dnn_d_r;

  logic              write_s, init_s, exec_s, m_valid_s, m_last_s, done_s, err_s;
  logic [A_W-1:0]    a_s;
  logic [31:0]       d_s;

  logic legal_s, w_hs_s, s_hs_s, m_hs_s, k_last_s, lane_last_s, dcnt_done_s;

  assign legal_s     = (in_num != 10'd0) && (in_num <= 10'(F_SIZE));
  assign w_hs_s      = w_ready_r && w_valid;
  assign s_hs_s      = s_ready_r && s_valid;
  assign m_hs_s      = m_valid_r && m_ready;
  assign k_last_s    = (k_r == n_r - 10'd1);
  assign lane_last_s = (lane_r == LANE_W'(F_NUM - 1));
  assign dcnt_done_s = (dcnt_r == 2'(DRAIN_CYC - 1));

  // Next-state decode of the pass phases.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start && legal_s) begin
          next_state_s = skip_wload ? INIT : WLOAD;
        end else begin
          next_state_s = IDLE;
        end
      end
      WLOAD: begin
        if (w_hs_s && k_last_s && lane_last_s) begin
          next_state_s = INIT;
        end else begin
          next_state_s = WLOAD;
        end
      end
      INIT: next_state_s = EXEC;
      EXEC: begin
        if (s_hs_s && k_last_s) begin
          next_state_s = DRAIN;
        end else begin
          next_state_s = EXEC;
        end
      end
      DRAIN: begin
        if (dcnt_done_s) begin
          next_state_s = OUT;
        end else begin
          next_state_s = DRAIN;
        end
      end
      OUT: begin
        if (m_hs_s && lane_last_s) begin
          next_state_s = IDLE;
        end else begin
          next_state_s = OUT;
        end
      end
      default: next_state_s = IDLE;
    endcase
  end

  // Next values of the registered array strobes and stream outputs.
  always_comb begin
    write_s   = 1'b0;
    init_s    = 1'b0;
    exec_s    = 1'b0;
    a_s       = dnn_a_r;
    d_s       = dnn_d_r;
    m_valid_s = 1'b0;
    m_last_s  = 1'b0;
    done_s    = 1'b0;
    err_s     = 1'b0;
    case (state_r)
      IDLE: err_s = start && !legal_s;
      WLOAD: begin
        if (w_hs_s) begin
          write_s = 1'b1;
          a_s     = {lane_r, k_r[ADDR_W-1:0]};
          d_s     = w_data;
        end else begin
          write_s = 1'b0;
        end
      end
      INIT: init_s = 1'b1;
      EXEC: begin
        if (s_hs_s) begin
          exec_s = 1'b1;
          a_s    = {{LANE_W{1'b0}}, k_r[ADDR_W-1:0]};
          d_s    = s_data;
        end else begin
          exec_s = 1'b0;
        end
      end
      DRAIN: begin
        if (dcnt_done_s) begin
          a_s = {A_W{1'b0}};
        end else begin
          a_s = dnn_a_r;
        end
      end
      OUT: begin
        // Lane address is presented one cycle ahead so dnn_x is ready when m_valid rises.
        if (!settle_r) begin
          m_valid_s = 1'b1;
          m_last_s  = lane_last_s;
        end else if (m_hs_s) begin
          a_s    = {{ADDR_W{1'b0}}, lane_r + 4'd1};
          done_s = lane_last_s;
        end else begin
          m_valid_s = 1'b1;
          m_last_s  = m_last_r;
        end
      end
      default: err_s = 1'b0;
    endcase
  end

  // State, counters and all registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      lane_r      <= 4'd0;
      k_r         <= 10'd0;
      n_r         <= 10'd0;
      dcnt_r      <= 2'd0;
      settle_r    <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      err_r       <= 1'b0;
      w_ready_r   <= 1'b0;
      s_ready_r   <= 1'b0;
      m_valid_r   <= 1'b0;
      m_last_r    <= 1'b0;
      dnn_write_r <= 1'b0;
      dnn_init_r  <= 1'b0;
      dnn_exec_r  <= 1'b0;
      dnn_a_r     <= 13'd0;
      dnn_d_r     <= 32'd0;
    end else begin
      state_r     <= next_state_s;
      busy_r      <= (next_state_s != IDLE);
      w_ready_r   <= (next_state_s == WLOAD);
      s_ready_r   <= (next_state_s == EXEC);
      done_r      <= done_s;
      err_r       <= err_s;
      m_valid_r   <= m_valid_s;
      m_last_r    <= m_last_s;
      dnn_write_r <= write_s;
      dnn_init_r  <= init_s;
      dnn_exec_r  <= exec_s;
      dnn_a_r     <= a_s;
      dnn_d_r     <= d_s;
      case (state_r)
        IDLE: begin
          if (start && legal_s) begin
            n_r    <= in_num;
            lane_r <= 4'd0;
            k_r    <= 10'd0;
          end
        end
        WLOAD: begin
          if (w_hs_s) begin
            if (k_last_s) begin
              k_r    <= 10'd0;
              lane_r <= lane_r + 4'd1;
            end else begin
              k_r <= k_r + 10'd1;
            end
          end
        end
        INIT: k_r <= 10'd0;
        EXEC: begin
          if (s_hs_s) begin
            k_r <= k_last_s ? 10'd0 : k_r + 10'd1;
          end
        end
        DRAIN: begin
          if (dcnt_done_s) begin
            dcnt_r   <= 2'd0;
            lane_r   <= 4'd0;
            settle_r <= 1'b0;
          end else begin
            dcnt_r <= dcnt_r + 2'd1;
          end
        end
        OUT: begin
          if (m_hs_s) begin
            lane_r   <= lane_r + 4'd1;
            settle_r <= 1'b0;
          end else begin
            settle_r <= 1'b1;
          end
        end
        default: dcnt_r <= 2'd0;
      endcase
    end
  end

  assign busy      = busy_r;
  assign done      = done_r;
  assign err       = err_r;
  assign w_ready   = w_ready_r;
  assign s_ready   = s_ready_r;
  assign m_valid   = m_valid_r;
  assign m_last    = m_last_r;
  // dnn_x is already a register inside the array; gate it so m_data is 0 when idle.
  assign m_data    = m_valid_r ? dnn_x : 32'd0;
  assign dnn_write = dnn_write_r;
  assign dnn_init  = dnn_init_r;
  assign dnn_exec  = dnn_exec_r;
  assign dnn_a     = dnn_a_r;
  assign dnn_d     = dnn_d_r;

endmodule

// File: tb/tb_tiny_dnn_seq.sv
// Bench for tiny_dnn_seq: a behavioural bf16 array model plus a dot-product
// reference computed directly from the weight/activation values.
module tb_tiny_dnn_seq;

  logic        clk, rst_n, start, skip_wload;
  logic [9:0]  in_num;
  logic        busy, done, err;
  logic        w_valid, w_ready, s_valid, s_ready, m_valid, m_ready, m_last;
  logic [31:0] w_data, s_data, m_data;
  logic        dnn_write, dnn_init, dnn_exec;
  logic [12:0] dnn_a;
  logic [31:0] dnn_d, dnn_x;

  tiny_dnn_seq dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_num(in_num), .skip_wload(skip_wload),
    .busy(busy), .done(done), .err(err),
    .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .dnn_write(dnn_write), .dnn_init(dnn_init), .dnn_exec(dnn_exec),
    .dnn_a(dnn_a), .dnn_d(dnn_d), .dnn_x(dnn_x)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic real f2r(input logic [31:0] b);
    real m;
    int  e;
    int  mi;
    if (b[30:23] == 8'd0) return 0.0;
    mi = int'({9'd0, b[22:0]});
    m  = 1.0 + $itor(mi) / 8388608.0;
    e  = int'({24'd0, b[30:23]}) - 127;
    while (e > 0) begin m = m * 2.0; e--; end
    while (e < 0) begin m = m / 2.0; e++; end
    return b[31] ? -m : m;
  endfunction

  function automatic logic [31:0] r2f(input real r);
    logic s;
    int   e;
    real  m;
    if (r == 0.0) return 32'd0;
    s = (r < 0.0);
    m = s ? -r : r;
    e = 0;
    while (m >= 2.0) begin m = m / 2.0; e++; end
    while (m < 1.0) begin m = m * 2.0; e--; end
    return {s, 8'(e + 127), 23'($rtoi((m - 1.0) * 8388608.0))};
  endfunction

  // Array model: bf16 weights and activations, exec result visible two cycles after the strobe.
  logic [15:0] wmem [8192];
  real         acc [16];
  logic        pend_v = 1'b0;
  logic [8:0]  pend_k = 9'd0;
  real         pend_d = 0.0;

  always @(posedge clk) begin
    if (pend_v)
      for (int l = 0; l < 16; l++)
        acc[l] <= acc[l] + f2r({wmem[{4'(l), pend_k}], 16'd0}) * pend_d;
    if (dnn_init)
      for (int l = 0; l < 16; l++) acc[l] <= 0.0;
    pend_v <= dnn_exec;
    pend_k <= dnn_a[8:0];
    pend_d <= f2r({dnn_d[31:16], 16'd0});
    if (dnn_write) wmem[dnn_a] <= dnn_d[31:16];
    if (!dnn_write && !dnn_init && !dnn_exec) dnn_x <= r2f(acc[dnn_a[3:0]]);
  end

  int n_write = 0, n_init = 0, n_exec = 0, n_done = 0, n_err = 0, n_multi = 0;

  always @(negedge clk) begin
    if (dnn_write) n_write <= n_write + 1;
    if (dnn_init)  n_init  <= n_init + 1;
    if (dnn_exec)  n_exec  <= n_exec + 1;
    if (done)      n_done  <= n_done + 1;
    if (err)       n_err   <= n_err + 1;
    if (int'(dnn_write) + int'(dnn_init) + int'(dnn_exec) > 1) n_multi <= n_multi + 1;
  end

  real         vals [8] = '{0.5, 1.0, 1.5, 2.0, 3.0, -1.0, -2.0, 4.0};
  real         wv [16][512];
  real         av [512];
  int          max_loaded = 0;
  logic [31:0] last_data;

  task automatic check_idle(input string tag);
    check_eq({tag, "_flags"}, {22'd0, busy, done, err, w_ready, s_ready, m_valid, m_last,
                               dnn_write, dnn_init, dnn_exec}, 32'd0);
    check_eq({tag, "_dnn_a"}, {19'd0, dnn_a}, 32'd0);
    check_eq({tag, "_dnn_d"}, dnn_d, 32'd0);
    check_eq({tag, "_m_data"}, m_data, 32'd0);
  endtask

  task automatic run_pass(input int n, input bit skip, input int vstall, input int rstall,
                          input int hold_res, input int hold_cyc, input int gap_k, input int gap_cyc);
    logic [31:0] expv [16];
    logic [31:0] t, prev_data;
    real  sum;
    int   wi, si, ri, cyc, gap_left, hold_left, w0, i0, e0, d0, r0;
    bit   wh, sh, prev_stall, prev_last, settle_chk;
    for (int l = 0; l < 16; l++) begin
      sum = 0.0;
      for (int k = 0; k < n; k++) sum = sum + wv[l][k] * av[k];
      expv[l] = r2f(sum);
    end
    if (!skip && n > max_loaded) max_loaded = n;
    w0 = n_write; i0 = n_init; e0 = n_exec; d0 = n_done; r0 = n_err;
    start = 1'b1; in_num = 10'(n); skip_wload = skip;
    @(posedge clk); #1;
    start = 1'b0;
    check_eq("busy_after_start", {31'd0, busy}, 32'd1);
    wi = 0; si = 0; ri = 0; cyc = 0; gap_left = 0; hold_left = hold_cyc;
    prev_stall = 1'b0; prev_last = 1'b0; prev_data = 32'd0; settle_chk = 1'b0;
    while (ri < 16 && cyc < 64 * n + 600) begin
      start = ($urandom_range(7) == 0);
      in_num = 10'($urandom);
      skip_wload = 1'($urandom);
      w_valid = (wi < 16 * n) && ($urandom_range(99) >= vstall);
      t = (wi < 16 * n) ? r2f(wv[wi / n][wi % n]) : $urandom;
      w_data = {t[31:16], 16'($urandom)};
      if (gap_left > 0) begin
        s_valid = 1'b0;
        gap_left--;
      end else begin
        s_valid = (si < n) && ($urandom_range(99) >= vstall);
      end
      t = (si < n) ? r2f(av[si]) : $urandom;
      s_data = {t[31:16], 16'($urandom)};
      if (m_valid && ri == hold_res && hold_left > 0) begin
        m_ready = 1'b0;
        hold_left--;
      end else begin
        m_ready = ($urandom_range(99) >= rstall);
      end
      if (prev_stall) begin
        check_eq("hold_valid", {31'd0, m_valid}, 32'd1);
        check_eq("hold_data", m_data, prev_data);
        check_eq("hold_last", {31'd0, m_last}, {31'd0, prev_last});
      end
      if (settle_chk) check_eq("settle_gap", {31'd0, m_valid}, 32'd0);
      settle_chk = 1'b0;
      if (m_valid && m_ready) begin
        check_eq($sformatf("result_%0d", ri), m_data, expv[ri]);
        check_eq($sformatf("last_%0d", ri), {31'd0, m_last}, (ri == 15) ? 32'd1 : 32'd0);
        last_data = m_data;
        ri++;
        settle_chk = 1'b1;
      end
      prev_stall = m_valid && !m_ready;
      prev_data = m_data;
      prev_last = m_last;
      wh = w_valid && w_ready;
      sh = s_valid && s_ready;
      @(posedge clk); #1;
      if (wh) wi++;
      if (sh) begin
        si++;
        if (si == gap_k) gap_left = gap_cyc;
      end
      cyc++;
    end
    start = 1'b0; w_valid = 1'b0; s_valid = 1'b0; m_ready = 1'b1;
    check_eq("result_count", ri, 32'd16);
    check_eq("done_pulse", {31'd0, done}, 32'd1);
    check_eq("busy_end", {31'd0, busy}, 32'd0);
    @(posedge clk); #1;
    check_eq("done_one_cycle", {31'd0, done}, 32'd0);
    check_eq("done_count", n_done - d0, 32'd1);
    check_eq("write_count", n_write - w0, skip ? 32'd0 : 32'(16 * n));
    check_eq("init_count", n_init - i0, 32'd1);
    check_eq("exec_count", n_exec - e0, 32'(n));
    check_eq("no_err_in_pass", n_err - r0, 32'd0);
  endtask

  task automatic err_test(input logic [9:0] bad, input string tag);
    int s0;
    s0 = n_write + n_init + n_exec;
    start = 1'b1; in_num = bad; skip_wload = 1'($urandom);
    @(posedge clk); #1;
    start = 1'b0;
    check_eq({tag, "_err"}, {31'd0, err}, 32'd1);
    check_eq({tag, "_busy"}, {31'd0, busy}, 32'd0);
    @(posedge clk); #1;
    check_eq({tag, "_err_clear"}, {31'd0, err}, 32'd0);
    check_eq({tag, "_busy_idle"}, {31'd0, busy}, 32'd0);
    check_eq({tag, "_no_strobe"}, n_write + n_init + n_exec - s0, 32'd0);
  endtask

  task automatic fill_random(input int n, input bit load);
    for (int k = 0; k < n; k++) av[k] = vals[$urandom_range(7)];
    if (load)
      for (int l = 0; l < 16; l++)
        for (int k = 0; k < n; k++) wv[l][k] = vals[$urandom_range(7)];
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit got, sh, skip;
    int n;
    rst_n = 1'b0; start = 1'b0; in_num = 10'd0; skip_wload = 1'b0;
    w_valid = 1'b0; w_data = 32'd0; s_valid = 1'b0; s_data = 32'd0; m_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_idle("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Full load of 1.0 weights, activations 2,3,4 -> 9.0 per lane.
    for (int l = 0; l < 16; l++) for (int k = 0; k < 3; k++) wv[l][k] = 1.0;
    av[0] = 2.0; av[1] = 3.0; av[2] = 4.0;
    run_pass(3, 1'b0, 0, 0, -1, 0, -1, 0);
    check_eq("t1_value", last_data, 32'h41100000);

    // Resident weights reused; accumulators must start from zero again.
    for (int k = 0; k < 3; k++) av[k] = 1.0;
    run_pass(3, 1'b1, 0, 0, -1, 0, -1, 0);
    check_eq("t2_value", last_data, 32'h40400000);

    // Five-cycle activation gap between the two execs.
    av[0] = 1.0; av[1] = 1.0;
    run_pass(2, 1'b1, 0, 0, -1, 0, 1, 5);
    check_eq("t3_value", last_data, 32'h40000000);

    // Result 7 back-pressured for ten cycles.
    for (int l = 0; l < 16; l++) for (int k = 0; k < 4; k++) wv[l][k] = 1.0;
    fill_random(4, 1'b0);
    run_pass(4, 1'b0, 0, 0, 7, 10, -1, 0);

    err_test(10'd0, "in_num_0");
    err_test(10'd600, "in_num_600");
    err_test(10'd513, "in_num_513");

    // Reset in EXEC after the k=0 activation.
    for (int k = 0; k < 4; k++) av[k] = 1.0;
    start = 1'b1; in_num = 10'd4; skip_wload = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    got = 1'b0;
    for (int c = 0; c < 20 && !got; c++) begin
      s_valid = 1'b1;
      s_data = 32'h3F800000;
      sh = s_ready;
      @(posedge clk); #1;
      if (sh) got = 1'b1;
    end
    check_eq("t6_first_exec", {31'd0, got}, 32'd1);
    s_valid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    check_idle("mid_reset");
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_pass(4, 1'b1, 0, 0, -1, 0, -1, 0);
    check_eq("t6_value", last_data, 32'h40800000);

    // Largest legal pass, then the smallest.
    fill_random(512, 1'b1);
    run_pass(512, 1'b0, 0, 0, -1, 0, -1, 0);
    fill_random(1, 1'b0);
    run_pass(1, 1'b1, 0, 0, -1, 0, -1, 0);

    for (int p = 0; p < 8; p++) begin
      n = $urandom_range(1, 9);
      skip = 1'($urandom) && (n <= max_loaded);
      fill_random(n, !skip);
      run_pass(n, skip, 30, 30, $urandom_range(15), $urandom_range(1, 6), -1, 0);
    end

    check_eq("single_strobe", n_multi, 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
